core_banked: RTL
================

# core_banked

Parametrised successor of the MARS core memory: stores `CORESIZE` Redcode instructions as six independently writable field banks, serves `NUM_RD` folded read ports with registered outputs, and sweeps the whole core to a configurable initial instruction after reset or on request. It sits between the MARS execution pipeline and the warrior loader. The pipeline issues PC-relative offsets, and this block applies read/write range folding internally.

## Interface
Parameters:
- `CORESIZE`, 8000: number of instruction slots. `AW = $clog2(CORESIZE)`.
- `READ_RANGE`, 8000: read folding limit.
- `WRITE_RANGE`, 8000: write folding limit.
- `NUM_RD`, 2: number of read ports. Range 1..4.
- `INIT_WORD`, 0: instruction written by the clear sweep. Encoding 0 is `DAT.F $0,$0`.

Instruction word, `IW = 14 + 2*AW` bits, MSB first: opcode[5], modif[3], amode[3], anumber[AW], bmode[3], bnumber[AW].

Ports:
- `i_clk`  in  1  clock. All state is updated on the rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_pc`  in  AW  base address shared by all ports.
- `i_roffs`  in  NUM_RD*AW  read offsets. Port k uses slice [k*AW +: AW].
- `i_rvalid`  in  NUM_RD  read request per port.
- `o_dout`  out  NUM_RD*IW  read data, registered.
- `o_rvalid`  out  NUM_RD  read data valid, registered.
- `i_woffs`  in  AW  write offset.
- `i_din`  in  IW  write data.
- `i_we`  in  6  per-field write enables. Bit 5 = opcode … bit 0 = bnumber.
- `i_clear`  in  1  request a full core clear.
- `o_busy`  out  1  high while clearing. Reads and writes are ignored while it is high.

## Operation
- Folding, applied per port with L = READ_RANGE or WRITE_RANGE:
  - r = offs % L.
  - f = (r > L/2) ? r + CORESIZE − L : r.
  - addr = (pc + f) % CORESIZE.
  - Intermediate sums are computed at AW+1 bits so they never overflow.
- FSM states: CLEAR and READY.
  - Reset enters CLEAR with the sweep counter at 0.
  - In CLEAR, INIT_WORD is written to all six banks at address counter, and the counter increments each cycle.
  - The cycle that writes CORESIZE−1 transitions to READY.
  - In READY, `i_clear`=1 transitions to CLEAR with the counter at 0. A write issued in that same cycle is still performed.
  - `i_clear` while already in CLEAR is ignored; the sweep does not restart.
- In READY, a write updates only the fields whose `i_we` bit is set. `i_we`=0 is a no-op.
- In READY, port k with `i_rvalid[k]`=1 reads the folded address and presents the data next cycle with `o_rvalid[k]`=1.
- In CLEAR, `i_we` and `i_rvalid` are ignored.
- Multiple ports may read the same address in the same cycle, and all of them return identical data.
- Read/write collision (same address, same cycle): see Configuration.
- Reset mid-sweep restarts the sweep from 0.

## Timing
- Read latency is 1 cycle. Data and valid are registered together. `o_dout[k]` holds its last value while `o_rvalid[k]`=0.
- Write latency is 1 cycle. A read issued the cycle after a write returns the new data.
- Clear takes exactly CORESIZE cycles. `o_busy` falls in the cycle after the last sweep write.
- Values after the reset edge:
  - `o_busy`=1.
  - `o_rvalid`=0.
  - `o_dout`=0.
  - Counter = 0.
  - Memory contents are undefined until the sweep completes.

## Configuration
- `CORE_FWD_EN` defined: on a read/write collision, fields whose `i_we` bit is set return `i_din` and the other fields return stored data. This is write-first behaviour per field.
- `CORE_FWD_EN` undefined: a colliding read returns the old contents of every field. This is read-first behaviour, and no forwarding logic is built.

## Structure
- Package `core_pkg` holds:
  - Field widths: OPCODE_W=5, MODIF_W=3, MODE_W=3.
  - The `IW` formula and field-slice offsets.
  - The opcode/modifier/mode enum typedefs.
  - A packed struct `instr_t`.
  - The `DAT_F_ZERO` constant.
- One sub-module, `core_fold`: combinational folding with parameters (CORESIZE, LIMIT). It is instantiated NUM_RD+1 times, once per read port and once for the write port.
- Each field bank is its own inferred RAM with 1 write port and NUM_RD read ports.

## Test plan
1. Reset held 3 cycles, then released:
   - `o_busy` stays high for exactly 8000 cycles.
   - Reads issued during that time give `o_rvalid`=0.
   - Afterwards, a read at pc=1234, offs=0 returns 0.
2. Folding with READ_RANGE=400, pc=10: offsets 7999, 250 and 200 return the contents of addresses 9, 7860 and 210 respectively. Verify by pre-writing distinct tags at those addresses.
3. Partial write: write 0x… with `i_we`=6'b000100 (anumber only) at pc=5, offs=0. The next-cycle read returns the previous opcode/modes/bnumber and the new anumber.
4. Collision: port 0 reads the address being written with `i_we`=6'h3F.
   - With `CORE_FWD_EN`, port 0 returns `i_din`.
   - Without it, port 0 returns the old word.
   - Port 1 reading the same address matches port 0.
5. `i_clear` pulsed in READY while a write is issued:
   - The write lands in the same cycle.
   - `o_busy` rises the next cycle.
   - After 8000 cycles every probed address reads INIT_WORD.
6. `i_rst_n` asserted mid-sweep (counter ≈ 4000):
   - The sweep restarts from 0.
   - `o_busy` is held for a full 8000 cycles after release.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the banked Redcode core: field widths, slice offsets,
// instruction encodings and the packed instruction layout at the default core size.
package core_pkg;

  localparam int OPCODE_W = 5;
  localparam int MODIF_W  = 3;
  localparam int MODE_W   = 3;
  localparam int NUM_FLD  = 6;
  localparam int DEF_AW   = 13;

  typedef enum logic [OPCODE_W-1:0] {
    OP_DAT = 5'd0,
    OP_MOV = 5'd1,
    OP_ADD = 5'd2,
    OP_SUB = 5'd3,
    OP_MUL = 5'd4,
    OP_DIV = 5'd5,
    OP_MOD = 5'd6,
    OP_JMP = 5'd7,
    OP_JMZ = 5'd8,
    OP_JMN = 5'd9,
    OP_DJN = 5'd10,
    OP_SEQ = 5'd11,
    OP_SNE = 5'd12,
    OP_SLT = 5'd13,
    OP_SPL = 5'd14,
    OP_NOP = 5'd15
  } opcode_e;

  typedef enum logic [MODIF_W-1:0] {
    MOD_F  = 3'd0,
    MOD_A  = 3'd1,
    MOD_B  = 3'd2,
    MOD_AB = 3'd3,
    MOD_BA = 3'd4,
    MOD_X  = 3'd5,
    MOD_I  = 3'd6
  } modif_e;

  typedef enum logic [MODE_W-1:0] {
    MODE_DIRECT    = 3'd0,
    MODE_IMMEDIATE = 3'd1,
    MODE_IND_B     = 3'd2,
    MODE_PREDEC_B  = 3'd3,
    MODE_POSTINC_B = 3'd4,
    MODE_IND_A     = 3'd5,
    MODE_PREDEC_A  = 3'd6,
    MODE_POSTINC_A = 3'd7
  } mode_e;

  typedef struct packed {
    opcode_e             opcode;
    modif_e              modif;
    mode_e               amode;
    logic [DEF_AW-1:0]   anumber;
    mode_e               bmode;
    logic [DEF_AW-1:0]   bnumber;
  } instr_t;

  localparam instr_t DAT_F_ZERO = '{
    opcode:  OP_DAT,
    modif:   MOD_F,
    amode:   MODE_DIRECT,
    anumber: '0,
    bmode:   MODE_DIRECT,
    bnumber: '0
  };

  function automatic int calc_iw(input int aw);
    return OPCODE_W + MODIF_W + 2 * MODE_W + 2 * aw;
  endfunction

  // Field index matches the write-enable bit: 0 = bnumber ... 5 = opcode.
  function automatic int fld_width(input int fld, input int aw);
    case (fld)
      0:       return aw;
      1:       return MODE_W;
      2:       return aw;
      3:       return MODE_W;
      4:       return MODIF_W;
      default: return OPCODE_W;
    endcase
  endfunction

  function automatic int fld_offset(input int fld, input int aw);
    int off;
    off = 0;
    for (int i = 0; i < fld; i++) off += fld_width(i, aw);
    return off;
  endfunction

endpackage

// File: rtl/core_fold.sv
// Combinational range folding: maps a PC-relative offset into an absolute core
// address, wrapping offsets above LIMIT/2 to the negative side.
module core_fold #(
  parameter int CORESIZE = 8000,
  parameter int LIMIT    = 8000,
  parameter int AW       = $clog2(CORESIZE)
) (
  input  logic [AW-1:0] i_pc,
  input  logic [AW-1:0] i_offs,
  output logic [AW-1:0] o_addr
);

  localparam logic [AW:0] W_CS   = (AW+1)'(CORESIZE);
  localparam logic [AW:0] W_LIM  = (AW+1)'(LIMIT);
  localparam logic [AW:0] W_HALF = (AW+1)'(LIMIT / 2);
  localparam logic [AW:0] W_ADJ  = (AW+1)'(CORESIZE - LIMIT);

  logic [AW:0] w_r;
  logic [AW:0] w_f;
  logic [AW:0] w_sum;

  // One extra bit keeps pc + folded offset (< 2*CORESIZE) from overflowing.
  always_comb begin
    w_r    = {1'b0, i_offs} % W_LIM;
    w_f    = (w_r > W_HALF) ? (w_r + W_ADJ) : w_r;
    w_sum  = {1'b0, i_pc} + w_f;
    o_addr = (w_sum >= W_CS) ? AW'(w_sum - W_CS) : w_sum[AW-1:0];
  end

endmodule

// File: rtl/core_banked.sv
// Banked MARS core memory: six field RAMs, NUM_RD folded read ports, clear sweep.
// Define CORE_FWD_EN for per-field write-first forwarding on read/write collisions.
module core_banked
  import core_pkg::*;
#(
  parameter int CORESIZE    = 8000,
  parameter int READ_RANGE  = 8000,
  parameter int WRITE_RANGE = 8000,
  parameter int NUM_RD      = 2,
  parameter logic [14+2*$clog2(CORESIZE)-1:0] INIT_WORD = '0,
  localparam int AW = $clog2(CORESIZE),
  localparam int IW = calc_iw(AW)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [AW-1:0]        i_pc,
  input  logic [NUM_RD*AW-1:0] i_roffs,
  input  logic [NUM_RD-1:0]    i_rvalid,
  output logic [NUM_RD*IW-1:0] o_dout,
  output logic [NUM_RD-1:0]    o_rvalid,
  input  logic [AW-1:0]        i_woffs,
  input  logic [IW-1:0]        i_din,
  input  logic [5:0]           i_we,
  input  logic                 i_clear,
  output logic                 o_busy
);

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_READY = 1'b1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(CORESIZE - 1);

  logic                 r_state;
  logic [AW-1:0]        r_cnt;
  logic                 w_ready;
  logic [AW-1:0]        w_waddr;
  logic [NUM_RD*AW-1:0] w_raddr;
  logic [NUM_RD*IW-1:0] w_rd_raw;
  logic [AW-1:0]        w_bank_addr;
  logic [IW-1:0]        w_bank_din;
  logic [5:0]           w_bank_we;
`ifdef CORE_FWD_EN
  logic [IW-1:0]        w_we_mask;
`endif

  assign w_ready = (r_state == ST_READY);
  assign o_busy  = (r_state == ST_CLEAR);

  // A clear request in READY restarts the sweep; one arriving mid-sweep is dropped.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_cnt == LAST_ADDR) begin
            r_state <= ST_READY;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
        default: begin
          if (i_clear) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

  core_fold #(
    .CORESIZE (CORESIZE),
    .LIMIT    (WRITE_RANGE),
    .AW       (AW)
  ) u_wfold (
    .i_pc   (i_pc),
    .i_offs (i_woffs),
    .o_addr (w_waddr)
  );

  always_comb begin
    w_bank_addr = r_cnt;
    w_bank_din  = INIT_WORD;
    w_bank_we   = '0;
    if (i_rst_n) begin
      if (w_ready) begin
        w_bank_addr = w_waddr;
        w_bank_din  = i_din;
        w_bank_we   = i_we;
      end else begin
        w_bank_we = '1;
      end
    end
  end

  for (genvar f = 0; f < NUM_FLD; f++) begin : g_bank
    localparam int FW = fld_width(f, AW);
    localparam int FO = fld_offset(f, AW);

    logic [FW-1:0] r_mem [CORESIZE];

    always_ff @(posedge i_clk) begin
      if (w_bank_we[f]) r_mem[w_bank_addr] <= w_bank_din[FO +: FW];
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      assign w_rd_raw[k*IW + FO +: FW] = r_mem[w_raddr[k*AW +: AW]];
    end

`ifdef CORE_FWD_EN
    assign w_we_mask[FO +: FW] = {FW{i_we[f]}};
`endif
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    logic          r_rv;
    logic [IW-1:0] r_dout;
    logic [IW-1:0] w_rd;

    core_fold #(
      .CORESIZE (CORESIZE),
      .LIMIT    (READ_RANGE),
      .AW       (AW)
    ) u_rfold (
      .i_pc   (i_pc),
      .i_offs (i_roffs[k*AW +: AW]),
      .o_addr (w_raddr[k*AW +: AW])
    );

`ifdef CORE_FWD_EN
    logic w_hit;
    assign w_hit = w_ready && (w_raddr[k*AW +: AW] == w_waddr);
    assign w_rd  = w_hit ? ((w_rd_raw[k*IW +: IW] & ~w_we_mask) | (i_din & w_we_mask))
                         : w_rd_raw[k*IW +: IW];
`else
    assign w_rd = w_rd_raw[k*IW +: IW];
`endif

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_rv   <= 1'b0;
        r_dout <= '0;
      end else begin
        r_rv <= w_ready & i_rvalid[k];
        if (w_ready && i_rvalid[k]) r_dout <= w_rd;
      end
    end

    assign o_rvalid[k]          = r_rv;
    assign o_dout[k*IW +: IW]   = r_dout;
  end

endmodule
